// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared state encoding and default sizes for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   localparam int unsigned c_aw_def  = 16;
   localparam int unsigned c_dw_def  = 16;
   localparam int unsigned c_tmo_def = 255;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_IF_BUSY = 3'd1,
      ST_DM_BUSY = 3'd2,
      ST_DUMP    = 3'd3,
      ST_HALT    = 3'd4
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch, data, memory and status signals of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int AW = c_aw_def,
   parameter int DW = c_dw_def
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          if_stall;

   logic          dm_en;
   logic          dm_wr;
   logic          dm_dump;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          dm_stall;

   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_dump;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;

   logic          halted;
   logic          err;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, dm_en, dm_wr, dm_dump, dm_addr, dm_wdata,
             mem_rdata, mem_done,
      output if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata, mem_dump, halted, err
   );

   // Requesters and memory model side
   modport master (
      output if_req, if_addr, dm_en, dm_wr, dm_dump, dm_addr, dm_wdata,
             mem_rdata, mem_done,
      input  if_ack, if_rdata, if_stall, dm_ack, dm_rdata, dm_stall,
             mem_rd, mem_wr, mem_addr, mem_wdata, mem_dump, halted, err
   );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-requester round-robin picker; req[1] = data, req[0] = fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
   input  wire        clk,
   input  wire        rst_n,
   input  wire  [1:0] req,
   input  wire        adv,
   output logic [1:0] grant
);

   logic r_last_dm;

   // On a tie the port not granted last wins; data wins the first tie.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = r_last_dm ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_dm <= 1'b0;
      end else if (adv && (req == 2'b11)) begin
         r_last_dm <= ~r_last_dm;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the unified memory between fetch and data paths, with
//               halt dump and a grant watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW  = c_aw_def,
   parameter int DW  = c_dw_def,
   parameter int TMO = c_tmo_def
) (
   input  wire          clk,
   input  wire          rst_n,
   mem_arbiter_if.slave bus
);

   localparam logic [2:0] c_idle    = ST_IDLE;
   localparam logic [2:0] c_if_busy = ST_IF_BUSY;
   localparam logic [2:0] c_dm_busy = ST_DM_BUSY;
   localparam logic [2:0] c_dump    = ST_DUMP;
   localparam logic [2:0] c_halt    = ST_HALT;
   localparam logic [7:0] c_wdog_lim = 8'(TMO - 1);

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic          r_mem_rd;
   logic          r_mem_wr;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [7:0]    r_wdog;
   logic          r_err;
   logic [1:0]    w_grant;
   logic          w_adv;
   logic          w_busy;
   logic          w_expire;
   logic          w_err_evt;

   assign w_busy   = (r_state == c_if_busy) || (r_state == c_dm_busy);
   // The TMO-th busy cycle without completion abandons the access.
   assign w_expire = w_busy && !bus.mem_done && (r_wdog == c_wdog_lim);
   assign w_adv    = (r_state == c_idle) && !bus.dm_dump;

   assign w_err_evt = (bus.mem_done && !w_busy)
                    || (bus.dm_dump && bus.dm_en)
                    || w_expire;

   rr_pick2 u_pick (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({bus.dm_en, bus.if_req}),
      .adv   (w_adv),
      .grant (w_grant)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle: begin
            if (bus.dm_dump) begin
               w_next = c_dump;
            end else if (w_grant[1]) begin
               w_next = c_dm_busy;
            end else if (w_grant[0]) begin
               w_next = c_if_busy;
            end
         end
         c_if_busy, c_dm_busy: begin
            if (bus.mem_done || w_expire) begin
               w_next = c_idle;
            end
         end
         c_dump:  w_next = c_halt;
         c_halt:  w_next = c_halt;
         default: w_next = c_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_idle;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wdog      <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
         if (w_busy) begin
            r_wdog <= r_wdog + 8'd1;
         end
         if ((r_state == c_idle) && (w_next == c_dm_busy)) begin
            r_mem_addr  <= bus.dm_addr;
            r_mem_wdata <= bus.dm_wdata;
            r_mem_rd    <= ~bus.dm_wr;
            r_mem_wr    <= bus.dm_wr;
            r_wdog      <= '0;
         end
         if ((r_state == c_idle) && (w_next == c_if_busy)) begin
            r_mem_addr <= bus.if_addr;
            r_mem_rd   <= 1'b1;
            r_wdog     <= '0;
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end
      end
   end

   // Acks are combinational on mem_done; a dropped request gets no ack.
   assign bus.if_ack   = (r_state == c_if_busy) && bus.mem_done && bus.if_req;
   assign bus.dm_ack   = ((r_state == c_dm_busy) && bus.mem_done && bus.dm_en)
                       || (r_state == c_dump);
   assign bus.if_stall = bus.if_req && !bus.if_ack;
   assign bus.dm_stall = (bus.dm_en || bus.dm_dump) && !bus.dm_ack;
   assign bus.if_rdata = bus.mem_rdata;
   assign bus.dm_rdata = bus.mem_rdata;

   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_dump  = (r_state == c_dump);
   assign bus.halted    = (r_state == c_halt);
   assign bus.err       = r_err;

endmodule
`default_nettype wire
